// File: rtl/keyboard_io_pkg.sv
// Shared constants for the keyboard I/O controller: register map, bit fields
// and FSM encoding.
package keyboard_io_pkg;

    localparam int unsigned RX_W      = 8;
    localparam int unsigned KB_DATA_W = 7;
    localparam int unsigned STAT_W    = 4;

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_DATA   = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_DROP   = 2'd3;

    localparam int unsigned STAT_KB_STATUS_BIT = 0;
    localparam int unsigned STAT_BUF_FULL_BIT  = 1;
    localparam int unsigned STAT_OVERRUN_BIT   = 2;
    localparam int unsigned STAT_IRQ_EN_BIT    = 3;

    localparam int unsigned CTRL_CLEAR_BIT  = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT = 1;

    localparam int unsigned DATA_VALID_BIT = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_CLR  = 2'd2,
        ST_ACK  = 2'd3
    } state_e;

endpackage

// File: rtl/kb_drop_counter.sv
// Saturating count of receiver bytes that could not be forwarded, plus a
// sticky overrun flag; clear has priority over increment.
module kb_drop_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o,
    output logic             overrun_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             overrun_q, overrun_d;

    always_comb begin
        count_d   = count_q;
        overrun_d = overrun_q;
        if (clr_i) begin
            count_d   = '0;
            overrun_d = 1'b0;
        end else if (inc_i) begin
            overrun_d = 1'b1;
            if (count_q != {CNT_W{1'b1}}) begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    assign count_o   = count_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/keyboard_io_ctrl.sv
// CPU bus front-end for keyboard_buf: forwards receiver bytes, serves the
// STATUS/DATA/CTRL/DROP registers and sequences buffer pop/clear pulses.
module keyboard_io_ctrl
    import keyboard_io_pkg::*;
#(
    parameter int unsigned BUS_W      = 64,
    parameter int unsigned DROP_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bus_req,
    input  logic                 bus_we,
    input  logic [1:0]           bus_addr,
    input  logic [BUS_W-1:0]     bus_wdata,
    output logic [BUS_W-1:0]     bus_rdata,
    output logic                 bus_ack,
    input  logic [RX_W-1:0]      rx_data,
    input  logic                 rx_done,
    output logic [RX_W-1:0]      kb_write_data,
    output logic                 kb_write,
    output logic                 kb_read_en,
    output logic                 kb_clear,
    input  logic                 kb_status,
    input  logic [KB_DATA_W-1:0] kb_read_data,
    input  logic                 kb_buf_full,
    output logic                 irq
);

    state_e                state_q, state_d;
    logic [BUS_W-1:0]      rdata_q, rdata_d;
    logic                  ack_q, ack_d;
    logic                  read_en_q, read_en_d;
    logic                  clear_q, clear_d;
    logic                  irq_en_q, irq_en_d;
    logic                  irq_q;
    logic [DROP_CNT_W-1:0] drop_cnt;
    logic                  overrun;
    logic                  drop_inc;
    logic [STAT_W-1:0]     status_vec;
    logic [1:0]            ctrl_vec;
    logic [RX_W-1:0]       pop_byte;
    logic                  unused_wdata;

    // Receiver bytes bypass the FSM; a clear in progress blocks the write.
    assign kb_write_data = rx_data;
    assign kb_write      = rx_done & ~kb_buf_full & (state_q != ST_CLR);
    assign drop_inc      = rx_done & ~kb_write;

    kb_drop_counter #(
        .CNT_W (DROP_CNT_W)
    ) u_drop_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_i     (drop_inc),
        .clr_i     (state_q == ST_CLR),
        .count_o   (drop_cnt),
        .overrun_o (overrun)
    );

    always_comb begin
        status_vec                     = '0;
        status_vec[STAT_KB_STATUS_BIT] = kb_status;
        status_vec[STAT_BUF_FULL_BIT]  = kb_buf_full;
        status_vec[STAT_OVERRUN_BIT]   = overrun;
        status_vec[STAT_IRQ_EN_BIT]    = irq_en_q;

        ctrl_vec                  = '0;
        ctrl_vec[CTRL_IRQ_EN_BIT] = irq_en_q;

        pop_byte                   = '0;
        pop_byte[KB_DATA_W-1:0]    = kb_read_data;
        pop_byte[DATA_VALID_BIT]   = 1'b1;
    end

    // Next-state logic; rdata is zero whenever no ack is pending.
    always_comb begin
        state_d  = state_q;
        rdata_d  = rdata_q;
        irq_en_d = irq_en_q;
        case (state_q)
            ST_IDLE: begin
                rdata_d = '0;
                if (bus_req) begin
                    state_d = ST_ACK;
                    if (!bus_we) begin
                        case (bus_addr)
                            REG_STATUS: rdata_d = BUS_W'(status_vec);
                            REG_DATA:   if (kb_status) state_d = ST_POP;
                            REG_CTRL:   rdata_d = BUS_W'(ctrl_vec);
                            default:    rdata_d = BUS_W'(drop_cnt);
                        endcase
                    end else if (bus_addr == REG_CTRL) begin
                        if (bus_wdata[CTRL_CLEAR_BIT]) begin
                            state_d = ST_CLR;
                        end else begin
                            irq_en_d = bus_wdata[CTRL_IRQ_EN_BIT];
                        end
                    end
                end
            end
            ST_POP: begin
                rdata_d = BUS_W'(pop_byte);
                state_d = ST_ACK;
            end
            ST_CLR: begin
                irq_en_d = bus_wdata[CTRL_IRQ_EN_BIT];
                state_d  = ST_ACK;
            end
            ST_ACK: begin
                rdata_d = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        ack_d     = (state_d == ST_ACK);
        read_en_d = (state_d == ST_POP);
        clear_d   = (state_d == ST_CLR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rdata_q   <= '0;
            ack_q     <= 1'b0;
            read_en_q <= 1'b0;
            clear_q   <= 1'b0;
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rdata_q   <= rdata_d;
            ack_q     <= ack_d;
            read_en_q <= read_en_d;
            clear_q   <= clear_d;
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_en_q & kb_status;
        end
    end

    assign unused_wdata = ^bus_wdata[BUS_W-1:2];

    assign bus_rdata  = rdata_q;
    assign bus_ack    = ack_q;
    assign kb_read_en = read_en_q;
    assign kb_clear   = clear_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_keyboard_io_ctrl.sv
// Directed bench for keyboard_io_ctrl: register-access vector table plus
// hand sequences for drops, clear/irq and reset during a pop.
module tb_keyboard_io_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bus_req;
    logic        bus_we;
    logic [1:0]  bus_addr;
    logic [63:0] bus_wdata;
    logic [63:0] bus_rdata;
    logic        bus_ack;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic [7:0]  kb_write_data;
    logic        kb_write;
    logic        kb_read_en;
    logic        kb_clear;
    logic        kb_status;
    logic [6:0]  kb_read_data;
    logic        kb_buf_full;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    keyboard_io_ctrl #(.BUS_W(64), .DROP_CNT_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus_req       (bus_req),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_rdata     (bus_rdata),
        .bus_ack       (bus_ack),
        .rx_data       (rx_data),
        .rx_done       (rx_done),
        .kb_write_data (kb_write_data),
        .kb_write      (kb_write),
        .kb_read_en    (kb_read_en),
        .kb_clear      (kb_clear),
        .kb_status     (kb_status),
        .kb_read_data  (kb_read_data),
        .kb_buf_full   (kb_buf_full),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [63:0] wdata;
        logic        st;
        logic        full;
        logic [6:0]  head;
        logic        chk_rd;
        logic [63:0] exp_rd;
        int          lat;
        int          pops;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the ack cycle.
    task automatic access(input logic we, input logic [1:0] addr, input logic [63:0] wdata,
                          input logic chk_rd, input logic [63:0] exp_rd, input int exp_lat,
                          input int exp_pops, input int exp_clrs, input string name);
        int lat  = 0;
        int pops = 0;
        int clrs = 0;
        bit got  = 1'b0;
        bus_req   = 1'b1;
        bus_we    = we;
        bus_addr  = addr;
        bus_wdata = wdata;
        for (int c = 0; c < 10 && !got; c++) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (kb_read_en) pops++;
            if (kb_clear) clrs++;
            if (bus_ack) got = 1'b1;
        end
        if (got) begin
            chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
            chk({name, "_pops"}, 64'(pops), 64'(exp_pops));
            chk({name, "_clrs"}, 64'(clrs), 64'(exp_clrs));
            if (chk_rd) chk({name, "_rdata"}, bus_rdata, exp_rd);
        end else begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: got no ack expected ack within 10 cycles", name);
        end
        bus_req = 1'b0;
        bus_we  = 1'b0;
        @(negedge clk);
        chk({name, "_ack_one_cycle"}, 64'(bus_ack), 64'd0);
    endtask

    initial begin
        int acks;
        rst_n = 1'b0; bus_req = 1'b0; bus_we = 1'b0; bus_addr = 2'd0; bus_wdata = '0;
        rx_data = '0; rx_done = 1'b0; kb_status = 1'b0; kb_read_data = '0; kb_buf_full = 1'b0;

        //          we    addr  wdata   st    full  head   chk   exp_rd  lat pops
        vecs[0]  = '{1'b0, 2'd0, 64'h0,  1'b1, 1'b0, 7'h00, 1'b1, 64'h1,  1, 0};
        vecs[1]  = '{1'b0, 2'd1, 64'h0,  1'b1, 1'b0, 7'h68, 1'b1, 64'hE8, 2, 1};
        vecs[2]  = '{1'b0, 2'd1, 64'h0,  1'b0, 1'b0, 7'h55, 1'b1, 64'h0,  1, 0};
        vecs[3]  = '{1'b0, 2'd2, 64'h0,  1'b0, 1'b0, 7'h00, 1'b1, 64'h0,  1, 0};
        vecs[4]  = '{1'b0, 2'd3, 64'h0,  1'b0, 1'b0, 7'h00, 1'b1, 64'h0,  1, 0};
        vecs[5]  = '{1'b1, 2'd2, 64'h2,  1'b0, 1'b0, 7'h00, 1'b0, 64'h0,  1, 0};
        vecs[6]  = '{1'b0, 2'd2, 64'h0,  1'b0, 1'b0, 7'h00, 1'b1, 64'h2,  1, 0};
        vecs[7]  = '{1'b0, 2'd0, 64'h0,  1'b0, 1'b1, 7'h00, 1'b1, 64'hA,  1, 0};
        vecs[8]  = '{1'b1, 2'd0, 64'hFF, 1'b0, 1'b0, 7'h00, 1'b0, 64'h0,  1, 0};
        vecs[9]  = '{1'b1, 2'd3, 64'hFF, 1'b0, 1'b0, 7'h00, 1'b0, 64'h0,  1, 0};
        vecs[10] = '{1'b0, 2'd3, 64'h0,  1'b0, 1'b0, 7'h00, 1'b1, 64'h0,  1, 0};
        vecs[11] = '{1'b1, 2'd2, 64'h0,  1'b0, 1'b0, 7'h00, 1'b0, 64'h0,  1, 0};
        vecs[12] = '{1'b0, 2'd0, 64'h0,  1'b1, 1'b1, 7'h00, 1'b1, 64'h3,  1, 0};

        repeat (3) @(negedge clk);
        chk("rst_ack", 64'(bus_ack), 64'd0);
        chk("rst_rdata", bus_rdata, 64'd0);
        chk("rst_read_en", 64'(kb_read_en), 64'd0);
        chk("rst_clear", 64'(kb_clear), 64'd0);
        chk("rst_irq", 64'(irq), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Forwarded receiver byte
        rx_data = 8'h68; rx_done = 1'b1;
        #1;
        chk("rx_write", 64'(kb_write), 64'd1);
        chk("rx_write_data", 64'(kb_write_data), 64'h68);
        @(negedge clk);
        rx_done = 1'b0;

        for (int i = 0; i < 13; i++) begin
            kb_status    = vecs[i].st;
            kb_buf_full  = vecs[i].full;
            kb_read_data = vecs[i].head;
            access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].chk_rd, vecs[i].exp_rd,
                   vecs[i].lat, vecs[i].pops, 0, $sformatf("vec%0d", i));
        end

        // Drops while the buffer is full
        kb_status = 1'b0; kb_buf_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rx_data = 8'(8'h30 + i); rx_done = 1'b1;
            #1;
            chk("full_no_write", 64'(kb_write), 64'd0);
            @(negedge clk);
            rx_done = 1'b0;
            @(negedge clk);
        end
        access(1'b0, 2'd3, 64'h0, 1'b1, 64'd3, 1, 0, 0, "drop3");
        access(1'b0, 2'd0, 64'h0, 1'b1, 64'h6, 1, 0, 0, "status_overrun");
        rx_done = 1'b1;
        repeat (297) @(negedge clk);
        rx_done = 1'b0;
        access(1'b0, 2'd3, 64'h0, 1'b1, 64'd255, 1, 0, 0, "drop_sat");

        // Clear with irq enable, then irq follows kb_status one cycle later
        kb_buf_full = 1'b0;
        access(1'b1, 2'd2, 64'h3, 1'b0, 64'h0, 2, 0, 1, "ctrl_clear");
        access(1'b0, 2'd3, 64'h0, 1'b1, 64'd0, 1, 0, 0, "drop_cleared");
        access(1'b0, 2'd0, 64'h0, 1'b1, 64'h8, 1, 0, 0, "status_cleared");
        kb_status = 1'b1;
        #1;
        chk("irq_not_yet", 64'(irq), 64'd0);
        @(negedge clk);
        chk("irq_set", 64'(irq), 64'd1);

        // Reset asserted while the pop pulse is active
        kb_read_data = 7'h11;
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = 2'd1;
        @(posedge clk);
        #1;
        chk("pre_rst_read_en", 64'(kb_read_en), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_read_en", 64'(kb_read_en), 64'd0);
        chk("midrst_ack", 64'(bus_ack), 64'd0);
        chk("midrst_irq", 64'(irq), 64'd0);
        bus_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus_ack) acks++;
        end
        chk("post_rst_no_ack", 64'(acks), 64'd0);
        kb_status = 1'b0;
        access(1'b0, 2'd0, 64'h0, 1'b1, 64'h0, 1, 0, 0, "post_rst_status");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
